axi_load_engine: RTL

Parametrised DRAM-to-SRAM load engine for the LSU. It accepts one load command, splits it into `NUM` AXI read bursts and issues each burst on the AR channel. Returned R beats are written into the selected on-chip SRAM at consecutive addresses. A burst that returns any error response is re-issued whole, up to `MAX_RETRY` times. The block sits between the controller/IDU command path and the AXI read master, and drives the RAM wrapper write port.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/load_beat_writer.sv | 42 ++++
 rtl/axi_load_engine.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: load-engine FSM states, AXI encodings and SRAM selects.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } load_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] SRAM_TYPE_IFM  = 2'd0;
  localparam logic [1:0] SRAM_TYPE_WGT  = 2'd1;
  localparam logic [1:0] SRAM_TYPE_BIAS = 2'd2;
  localparam logic [1:0] SRAM_TYPE_OFM  = 2'd3;

endpackage

// File: rtl/load_beat_writer.sv
// Registered SRAM write stage: one write per good beat until the burst goes bad.
module load_beat_writer #(
  parameter int DATA_W  = 32,
  parameter int SRAM_AW = 8,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               beat_acc,
  input  logic               beat_err,
  input  logic               bad,
  input  logic [SRAM_AW-1:0] base,
  input  logic [LEN_W-1:0]   beat_cnt,
  input  logic [DATA_W-1:0]  rdata,
  output logic               sram_vld,
  output logic               sram_wen,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_din
);

  logic wr;

  // Once a burst has gone bad its remaining beats are dropped; the retry rewrites them.
  assign wr = beat_acc && !beat_err && !bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_vld  <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      sram_vld <= wr;
      if (wr) begin
        sram_addr <= base + SRAM_AW'(beat_cnt);
        sram_din  <= rdata;
      end
    end
  end

  assign sram_wen = sram_vld;

endmodule

// File: rtl/axi_load_engine.sv
// DRAM-to-SRAM load engine: splits a command into AXI INCR read bursts, retries
// bursts that return errors, and streams good beats into the selected SRAM.
module axi_load_engine
  import lsu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DRAM_AW   = 12,
  parameter int SRAM_AW   = 8,
  parameter int ID_W      = 8,
  parameter int LEN_W     = 8,
  parameter int NUM_W     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic [ID_W-1:0]    cmd_id,
  input  logic [DRAM_AW-1:0] cmd_dram_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [2:0]         cmd_size,
  input  logic [NUM_W-1:0]   cmd_num,
  input  logic [SRAM_AW-1:0] cmd_sram_addr,
  input  logic [1:0]         cmd_sram_type,
  output logic [ID_W-1:0]    axi_arid,
  output logic [DRAM_AW-1:0] axi_araddr,
  output logic [LEN_W-1:0]   axi_arlen,
  output logic [2:0]         axi_arsize,
  output logic [1:0]         axi_arburst,
  output logic               axi_arvld,
  input  logic               axi_arrdy,
  input  logic [ID_W-1:0]    axi_rid,
  input  logic [DATA_W-1:0]  axi_rdata,
  input  logic [1:0]         axi_rresp,
  input  logic               axi_rlast,
  input  logic               axi_rvld,
  output logic               axi_rrdy,
  output logic               sram_vld,
  output logic               sram_wen,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_din,
  output logic [1:0]         sram_type,
  output logic               done,
  output logic               err
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  load_state_e state, state_nxt;

  logic [ID_W-1:0]    id_q;
  logic [DRAM_AW-1:0] dram_addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [2:0]         size_q;
  logic [NUM_W-1:0]   num_m1_q;
  logic [NUM_W-1:0]   burst_cnt;
  logic [SRAM_AW-1:0] sram_base;
  logic [1:0]         sram_type_q;
  logic [RW-1:0]      retry_cnt;
  logic [LEN_W-1:0]   beat_cnt;
  logic               bad;
  logic               err_q;

  logic               beat_acc;
  logic               beat_err;
  logic               bad_now;
  logic               last_beat;
  logic               retry_ok;
  logic               burst_last;
  logic [DRAM_AW-1:0] dram_step;

  assign beat_acc   = (state == ST_DATA) && axi_rvld;
  assign beat_err   = (axi_rresp != AXI_RESP_OKAY) || (axi_rid != id_q);
  // Includes the current beat, so the rlast decision sees an error on the last beat.
  assign bad_now    = bad || beat_err || (axi_rlast && (beat_cnt != len_q));
  assign last_beat  = beat_acc && axi_rlast;
  assign retry_ok   = retry_cnt < RW'(MAX_RETRY);
  assign burst_last = burst_cnt == num_m1_q;
  assign dram_step  = (DRAM_AW'(len_q) + DRAM_AW'(1)) << size_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_vld) state_nxt = ST_ADDR;
      ST_ADDR: if (axi_arrdy) state_nxt = ST_DATA;
      ST_DATA: begin
        if (last_beat) begin
          if (bad_now) state_nxt = retry_ok ? ST_ADDR : ST_DONE;
          else         state_nxt = burst_last ? ST_DONE : ST_ADDR;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q        <= '0;
      dram_addr_q <= '0;
      len_q       <= '0;
      size_q      <= '0;
      num_m1_q    <= '0;
      burst_cnt   <= '0;
      sram_base   <= '0;
      sram_type_q <= '0;
      retry_cnt   <= '0;
      beat_cnt    <= '0;
      bad         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_vld) begin
            id_q        <= cmd_id;
            dram_addr_q <= cmd_dram_addr;
            len_q       <= cmd_len;
            size_q      <= cmd_size;
            num_m1_q    <= (cmd_num == '0) ? '0 : cmd_num - NUM_W'(1);
            sram_base   <= cmd_sram_addr;
            sram_type_q <= cmd_sram_type;
            burst_cnt   <= '0;
            retry_cnt   <= '0;
            beat_cnt    <= '0;
            bad         <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (axi_arrdy) begin
            beat_cnt <= '0;
            bad      <= 1'b0;
          end
        end
        ST_DATA: begin
          if (beat_acc) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            bad      <= bad_now;
            if (axi_rlast) begin
              if (bad_now) begin
                if (retry_ok) retry_cnt <= retry_cnt + RW'(1);
                else          err_q     <= 1'b1;
              end else if (!burst_last) begin
                burst_cnt   <= burst_cnt + NUM_W'(1);
                retry_cnt   <= '0;
                dram_addr_q <= dram_addr_q + dram_step;
                sram_base   <= sram_base + SRAM_AW'(len_q) + SRAM_AW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  load_beat_writer #(
    .DATA_W  (DATA_W),
    .SRAM_AW (SRAM_AW),
    .LEN_W   (LEN_W)
  ) u_writer (
    .clk       (clk),
    .rst_n     (rst_n),
    .beat_acc  (beat_acc),
    .beat_err  (beat_err),
    .bad       (bad),
    .base      (sram_base),
    .beat_cnt  (beat_cnt),
    .rdata     (axi_rdata),
    .sram_vld  (sram_vld),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_din  (sram_din)
  );

  assign cmd_rdy     = (state == ST_IDLE);
  assign axi_arvld   = (state == ST_ADDR);
  assign axi_rrdy    = (state == ST_DATA);
  assign done        = (state == ST_DONE);
  assign err         = err_q;
  assign axi_arid    = id_q;
  assign axi_araddr  = dram_addr_q;
  assign axi_arlen   = len_q;
  assign axi_arsize  = size_q;
  assign axi_arburst = AXI_BURST_INCR;
  assign sram_type   = sram_type_q;

endmodule
